// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
// ---------------------------------------------------------------------------
// Frame controller for PIXEL_ARRAY.
// A single frame runs through these phases:
//   ERASE -> GAP -> EXPOSE -> GAP -> CONVERT -> GAP -> READ.
// Each phase has a programmable length. A GAP cycle between phases keeps
// every phase output low. During CONVERT the block also generates the
// digital ramp code.
//
// Ports:
//   clk            in   system clock; all logic is on the rising edge
//   reset          in   asynchronous, active-low reset
//   start          in   begins one frame; only looked at in IDLE
//   abort          in   synchronous abort back to IDLE from any state
//   expose_cycles  in   exposure length in cycles; latched when a frame starts
//   continuous     in   (optional) chains frames back-to-back
//   erase          out  pixel erase (ERASE phase)
//   expose         out  exposure enable, gates VBN1 (EXPOSE phase)
//   ramp_en        out  gates ANALOG_RAMP / COUNTER_CLOCK (CONVERT phase)
//   write_enable   out  high in EXPOSE and CONVERT
//   counter_reset  out  one-cycle pulse in the GAP that follows CONVERT
//   read           out  array readout enable (READ phase)
//   power_enable   out  high in EXPOSE, CONVERT and READ
//   ramp_code      out  ramp value: 0 .. C_CONVERT-1 across CONVERT
//   busy           out  high in every state except IDLE
//   frame_done     out  one-cycle pulse when READ completes
//   state_o        out  current state encoding
//
// Optional feature: macro PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN.
// When it is defined, the `continuous` input is added. If `continuous` is
// high when READ completes, frame_done still pulses. The sequencer then goes
// through a GAP straight into ERASE, and re-latches expose_cycles on the
// edge that leaves that GAP.
// ---------------------------------------------------------------------------
module pixel_frame_sequencer #(
  parameter int BIT_DEPTH = 8,
  parameter int C_ERASE   = 5,
  parameter int C_CONVERT = 255,
  parameter int C_READ    = 5,
  parameter int EXP_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [EXP_W-1:0]     expose_cycles,
`ifdef PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN
  input  logic                 continuous,
`endif
  output logic                 erase,
  output logic                 expose,
  output logic                 ramp_en,
  output logic                 write_enable,
  output logic                 counter_reset,
  output logic                 read,
  output logic                 power_enable,
  output logic [BIT_DEPTH-1:0] ramp_code,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // The phase counter must hold the largest fixed phase length, and also
  // any exposure length that EXP_W bits can express.
  localparam int MAX_C0 = (C_ERASE > C_CONVERT) ? C_ERASE : C_CONVERT;
  localparam int MAX_C  = (MAX_C0 > C_READ) ? MAX_C0 : C_READ;
  localparam int C_W    = $clog2(MAX_C + 1);
  localparam int CNT_W  = (EXP_W > C_W) ? EXP_W : C_W;

  localparam logic [CNT_W-1:0] ERASE_LOAD   = CNT_W'(C_ERASE - 1);
  localparam logic [CNT_W-1:0] CONVERT_LOAD = CNT_W'(C_CONVERT - 1);
  localparam logic [CNT_W-1:0] READ_LOAD    = CNT_W'(C_READ - 1);

  state_t               state_q, state_d;
  state_t               gap_next_q, gap_next_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EXP_W-1:0]     exp_len_q, exp_len_d;
  logic [EXP_W-1:0]     exp_sample;
  logic                 read_last_continues;

  logic                 erase_d, expose_d, ramp_en_d, write_enable_d;
  logic                 counter_reset_d, read_d, power_enable_d;
  logic                 busy_d, frame_done_d;
  logic [BIT_DEPTH-1:0] ramp_code_d;

  // A zero exposure request still gives a single EXPOSE cycle.
  assign exp_sample = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;

`ifdef PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN
  assign read_last_continues = continuous;
`else
  assign read_last_continues = 1'b0;
`endif

  // State register, together with the phase counter, the latched exposure
  // length and the registered outputs. The outputs are computed from the
  // next state, so they change on the same edge as state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      gap_next_q    <= ST_IDLE;
      cnt_q         <= '0;
      exp_len_q     <= '0;
      erase         <= 1'b0;
      expose        <= 1'b0;
      ramp_en       <= 1'b0;
      write_enable  <= 1'b0;
      counter_reset <= 1'b0;
      read          <= 1'b0;
      power_enable  <= 1'b0;
      ramp_code     <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_next_q    <= gap_next_d;
      cnt_q         <= cnt_d;
      exp_len_q     <= exp_len_d;
      erase         <= erase_d;
      expose        <= expose_d;
      ramp_en       <= ramp_en_d;
      write_enable  <= write_enable_d;
      counter_reset <= counter_reset_d;
      read          <= read_d;
      power_enable  <= power_enable_d;
      ramp_code     <= ramp_code_d;
      busy          <= busy_d;
      frame_done    <= frame_done_d;
    end
  end

  assign state_o = state_q;

  // Next-state logic. Each phase counts down from (length-1) and leaves when
  // the counter reaches zero. Every phase exits through GAP, which holds the
  // phase to enter next and loads that phase's counter on the way out.
  always_comb begin
    state_d    = state_q;
    gap_next_d = gap_next_q;
    cnt_d      = cnt_q;
    exp_len_d  = exp_len_q;

    if (state_q != ST_IDLE && abort) begin
      state_d    = ST_IDLE;
      gap_next_d = ST_IDLE;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            exp_len_d = exp_sample;
            state_d   = ST_ERASE;
            cnt_d     = ERASE_LOAD;
          end
        end

        ST_ERASE: begin
          if (cnt_q == '0) begin
            state_d    = ST_GAP;
            gap_next_d = ST_EXPOSE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_EXPOSE: begin
          if (cnt_q == '0) begin
            state_d    = ST_GAP;
            gap_next_d = ST_CONVERT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_CONVERT: begin
          if (cnt_q == '0) begin
            state_d    = ST_GAP;
            gap_next_d = ST_READ;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_READ: begin
          if (cnt_q == '0) begin
            if (read_last_continues) begin
              state_d    = ST_GAP;
              gap_next_d = ST_ERASE;
            end else begin
              state_d    = ST_IDLE;
              gap_next_d = ST_IDLE;
              cnt_d      = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_GAP: begin
          state_d = gap_next_q;
          case (gap_next_q)
            ST_EXPOSE:  cnt_d = CNT_W'(exp_len_q - EXP_W'(1));
            ST_CONVERT: cnt_d = CONVERT_LOAD;
            ST_READ:    cnt_d = READ_LOAD;
            ST_ERASE: begin
              // A chained frame picks up the current exposure request here.
              cnt_d     = ERASE_LOAD;
              exp_len_d = exp_sample;
            end
            default:    cnt_d = '0;
          endcase
        end

        default: begin
          state_d    = ST_IDLE;
          gap_next_d = ST_IDLE;
          cnt_d      = '0;
        end
      endcase
    end
  end

  // Output decode, computed from the state being entered.
  // counter_reset and frame_done mark completed transitions out of CONVERT
  // and READ. An abort sends the state to IDLE, so it never produces either
  // pulse.
  always_comb begin
    erase_d         = (state_d == ST_ERASE);
    expose_d        = (state_d == ST_EXPOSE);
    ramp_en_d       = (state_d == ST_CONVERT);
    read_d          = (state_d == ST_READ);
    write_enable_d  = (state_d == ST_EXPOSE) || (state_d == ST_CONVERT);
    power_enable_d  = (state_d == ST_EXPOSE) || (state_d == ST_CONVERT) ||
                      (state_d == ST_READ);
    busy_d          = (state_d != ST_IDLE);
    counter_reset_d = (state_q == ST_CONVERT) && (state_d == ST_GAP);
    frame_done_d    = (state_q == ST_READ) && !abort &&
                      ((state_d == ST_IDLE) || (state_d == ST_GAP));
    ramp_code_d     = '0;
    if (state_d == ST_CONVERT && state_q == ST_CONVERT) begin
      ramp_code_d = ramp_code + BIT_DEPTH'(1);
    end
  end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// tb_pixel_frame_sequencer
// ---------------------------------------------------------------------------
// Self-checking bench for pixel_frame_sequencer. It runs two instances that
// share the same inputs:
//   u_dut_a  default parameters
//   u_dut_b  short phases (C_ERASE=2, C_CONVERT=4, C_READ=2)
// The reference model tracks each frame as an offset from its start edge.
// It derives the expected phase from the cumulative phase lengths.
// Define PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN to also exercise chained frames.
// ---------------------------------------------------------------------------
module tb_pixel_frame_sequencer;

  localparam int BD    = 8;
  localparam int EXP_W = 16;
  localparam int A_CE = 5, A_CC = 255, A_CR = 5;
  localparam int B_CE = 2, B_CC = 4,   B_CR = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [EXP_W-1:0] expose_cycles;
  logic             continuous;

  logic a_erase, a_expose, a_ramp_en, a_write_enable, a_counter_reset;
  logic a_read, a_power_enable, a_busy, a_frame_done;
  logic [BD-1:0] a_ramp_code;
  logic [2:0]    a_state_o;
  logic b_erase, b_expose, b_ramp_en, b_write_enable, b_counter_reset;
  logic b_read, b_power_enable, b_busy, b_frame_done;
  logic [BD-1:0] b_ramp_code;
  logic [2:0]    b_state_o;
  logic [19:0]   a_out, b_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one slot per instance.
  // m_t is the offset within the current frame. -1 marks the chained GAP.
  int   m_active[2];
  int   m_t[2];
  int   m_exp[2];
  logic m_fd[2];

  typedef struct {
    int         off;
    logic [2:0] st;
    logic [7:0] rc;
    logic       crst;
    logic       fd;
  } tv_t;
  tv_t tab[16];

  always #5 clk = ~clk;

  pixel_frame_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .expose_cycles(expose_cycles),
`ifdef PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN
    .continuous(continuous),
`endif
    .erase(a_erase), .expose(a_expose), .ramp_en(a_ramp_en),
    .write_enable(a_write_enable), .counter_reset(a_counter_reset),
    .read(a_read), .power_enable(a_power_enable), .ramp_code(a_ramp_code),
    .busy(a_busy), .frame_done(a_frame_done), .state_o(a_state_o)
  );

  pixel_frame_sequencer #(.C_ERASE(B_CE), .C_CONVERT(B_CC), .C_READ(B_CR)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .expose_cycles(expose_cycles),
`ifdef PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN
    .continuous(continuous),
`endif
    .erase(b_erase), .expose(b_expose), .ramp_en(b_ramp_en),
    .write_enable(b_write_enable), .counter_reset(b_counter_reset),
    .read(b_read), .power_enable(b_power_enable), .ramp_code(b_ramp_code),
    .busy(b_busy), .frame_done(b_frame_done), .state_o(b_state_o)
  );

  assign a_out = {a_state_o, a_ramp_code, a_erase, a_expose, a_ramp_en, a_write_enable,
                  a_counter_reset, a_read, a_power_enable, a_busy, a_frame_done};
  assign b_out = {b_state_o, b_ramp_code, b_erase, b_expose, b_ramp_en, b_write_enable,
                  b_counter_reset, b_read, b_power_enable, b_busy, b_frame_done};

  // Builds the full expected output word from a state code and the pulses.
  function automatic logic [19:0] pack_out(input logic [2:0] st, input logic [7:0] rc,
                                           input logic crst, input logic fd);
    logic er, ex, re, rd, we, pe, bz;
    er = (st == 3'd1);
    ex = (st == 3'd2);
    re = (st == 3'd3);
    rd = (st == 3'd4);
    we = ex | re;
    pe = ex | re | rd;
    bz = (st != 3'd0);
    return {st, rc, er, ex, re, we, crst, rd, pe, bz, fd};
  endfunction

  function automatic int p_ce(input int i); return (i == 0) ? A_CE : B_CE; endfunction
  function automatic int p_cc(input int i); return (i == 0) ? A_CC : B_CC; endfunction
  function automatic int p_cr(input int i); return (i == 0) ? A_CR : B_CR; endfunction

  function automatic int frame_len(input int i);
    return p_ce(i) + m_exp[i] + p_cc(i) + p_cr(i) + 3;
  endfunction

  // Maps a frame offset onto the phase windows laid end to end.
  function automatic logic [19:0] model_out(input int i);
    int t, e, ce, cc;
    logic [2:0] st;
    logic [7:0] rc;
    logic crst;
    st = 3'd0; rc = 8'd0; crst = 1'b0;
    t = m_t[i]; e = m_exp[i]; ce = p_ce(i); cc = p_cc(i);
    if (m_active[i] != 0) begin
      if (t == -1)                     st = 3'd5;
      else if (t < ce)                 st = 3'd1;
      else if (t == ce)                st = 3'd5;
      else if (t < ce + 1 + e)         st = 3'd2;
      else if (t == ce + 1 + e)        st = 3'd5;
      else if (t < ce + 2 + e + cc) begin
        st = 3'd3;
        rc = 8'(t - (ce + 2 + e));
      end else if (t == ce + 2 + e + cc) begin
        st = 3'd5;
        crst = 1'b1;
      end else                         st = 3'd4;
    end
    return pack_out(st, rc, crst, m_fd[i]);
  endfunction

  // Advances the model by one rising edge, using the inputs sampled at that edge.
  task automatic model_step(input int i);
    m_fd[i] = 1'b0;
    if (m_active[i] != 0) begin
      if (abort) begin
        m_active[i] = 0;
      end else if (m_t[i] == -1) begin
        m_t[i]   = 0;
        m_exp[i] = (expose_cycles == 0) ? 1 : int'(expose_cycles);
      end else begin
        m_t[i]++;
        if (m_t[i] == frame_len(i)) begin
          m_fd[i] = 1'b1;
          if (continuous) m_t[i] = -1;
          else            m_active[i] = 0;
        end
      end
    end else if (start && !abort) begin
      m_active[i] = 1;
      m_t[i]      = 0;
      m_exp[i]    = (expose_cycles == 0) ? 1 : int'(expose_cycles);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_t[i] = 0; m_exp[i] = 0; m_fd[i] = 1'b0;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic a, input int e);
    start         = s;
    abort         = a;
    expose_cycles = EXP_W'(e);
  endtask

  // One clock: update the model at the edge, then compare both instances 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_output("model_a", 32'(a_out), 32'(model_out(0)));
    check_output("model_b", 32'(b_out), 32'(model_out(1)));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    apply_stimulus(0, 0, int'(expose_cycles));
    while ((a_busy || b_busy) && n < 2000) begin
      tick();
      n++;
    end
    check_output("wait_idle", 32'({a_busy, b_busy}), 32'd0);
    tick();
  endtask

  initial begin
    int ti, cnt, ridx, fd_seen, seen, done;
    logic pulsed, prev_conv;

    // Frame windows for the default instance, as offsets from the start edge.
    tab[0]  = '{0,   3'd1, 8'd0,   1'b0, 1'b0};
    tab[1]  = '{4,   3'd1, 8'd0,   1'b0, 1'b0};
    tab[2]  = '{5,   3'd5, 8'd0,   1'b0, 1'b0};
    tab[3]  = '{6,   3'd2, 8'd0,   1'b0, 1'b0};
    tab[4]  = '{100, 3'd2, 8'd0,   1'b0, 1'b0};
    tab[5]  = '{260, 3'd2, 8'd0,   1'b0, 1'b0};
    tab[6]  = '{261, 3'd5, 8'd0,   1'b0, 1'b0};
    tab[7]  = '{262, 3'd3, 8'd0,   1'b0, 1'b0};
    tab[8]  = '{263, 3'd3, 8'd1,   1'b0, 1'b0};
    tab[9]  = '{400, 3'd3, 8'd138, 1'b0, 1'b0};
    tab[10] = '{516, 3'd3, 8'd254, 1'b0, 1'b0};
    tab[11] = '{517, 3'd5, 8'd0,   1'b1, 1'b0};
    tab[12] = '{518, 3'd4, 8'd0,   1'b0, 1'b0};
    tab[13] = '{522, 3'd4, 8'd0,   1'b0, 1'b0};
    tab[14] = '{523, 3'd0, 8'd0,   1'b0, 1'b1};
    tab[15] = '{524, 3'd0, 8'd0,   1'b0, 1'b0};

    model_reset();
    continuous = 1'b0;
    reset = 1'b0;
    apply_stimulus(0, 0, 0);
    #1;
    check_output("reset_a", 32'(a_out), 32'd0);
    check_output("reset_b", 32'(b_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();

    // Default frame timing against the table.
    $display("[TB] default frame timing");
    ti = 0;
    apply_stimulus(1, 0, 255);
    for (int off = 0; off <= 524; off++) begin
      tick();
      if (off == 0) apply_stimulus(0, 0, 255);
      if (ti < 16 && tab[ti].off == off) begin
        check_output($sformatf("timing@%0d", off), 32'(a_out),
                     32'(pack_out(tab[ti].st, tab[ti].rc, tab[ti].crst, tab[ti].fd)));
        ti++;
      end
    end
    wait_idle();

    // Asynchronous reset in the middle of CONVERT.
    $display("[TB] reset mid-convert");
    apply_stimulus(1, 0, 3);
    tick();
    apply_stimulus(0, 0, 3);
    for (int off = 1; off <= 110; off++) tick();
    check_output("pre_reset_ramp", 32'(a_ramp_code), 32'd100);
    reset = 1'b0;
    #1;
    check_output("async_reset_a", 32'(a_out), 32'd0);
    check_output("async_reset_b", 32'(b_out), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) tick();

    // A zero exposure request, then 3, on the short instance.
    $display("[TB] short exposures and ramp");
    for (int k = 0; k < 2; k++) begin
      wait_idle();
      apply_stimulus(1, 0, (k == 0) ? 0 : 3);
      tick();
      apply_stimulus(0, 0, 7);
      cnt = 0; ridx = 0; prev_conv = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (b_state_o == 3'd2) cnt++;
        if (b_state_o == 3'd3) begin
          check_output($sformatf("ramp_seq%0d", ridx), 32'(b_ramp_code), 32'(ridx));
          ridx++;
        end else if (prev_conv) begin
          check_output("ramp_after", 32'(b_ramp_code), 32'd0);
        end
        prev_conv = (b_state_o == 3'd3);
        tick();
      end
      check_output($sformatf("expose_len%0d", k), 32'(cnt), (k == 0) ? 32'd1 : 32'd3);
      check_output("ramp_count", 32'(ridx), 32'd4);
    end

    // Abort on the 10th EXPOSE cycle, then start held together with abort.
    $display("[TB] abort");
    wait_idle();
    apply_stimulus(1, 0, 50);
    tick();
    apply_stimulus(0, 0, 50);
    for (int off = 1; off <= 15; off++) tick();
    check_output("abort_pre_state", 32'(a_state_o), 32'd2);
    apply_stimulus(0, 1, 50);
    tick();
    check_output("abort_busy", 32'({a_busy, b_busy}), 32'd0);
    apply_stimulus(0, 0, 50);
    seen = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (a_frame_done || a_counter_reset || b_frame_done || b_counter_reset) seen++;
    end
    check_output("abort_no_pulses", 32'(seen), 32'd0);
    apply_stimulus(1, 1, 50);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (a_busy || b_busy) seen++;
    end
    check_output("start_with_abort", 32'(seen), 32'd0);

    // Start during READ is ignored; mid-frame exposure changes are ignored.
    $display("[TB] busy start and exposure change");
    wait_idle();
    apply_stimulus(1, 0, 4);
    tick();
    apply_stimulus(0, 0, 40);
    cnt = 0; pulsed = 1'b0; done = 0;
    for (int c = 0; c < 400 && done == 0; c++) begin
      if (a_frame_done) done = 1;
      else begin
        if (a_state_o == 3'd2) cnt++;
        if (a_state_o == 3'd4 && !pulsed) begin
          start = 1'b1;
          pulsed = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
      end
    end
    start = 1'b0;
    check_output("busy_frame_done", 32'(done), 32'd1);
    check_output("expose_len_kept", 32'(cnt), 32'd4);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (a_busy) seen++;
    end
    check_output("no_queued_start", 32'(seen), 32'd0);

`ifdef PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN
    // Three chained frames on the short instance; continuous drops during frame 3.
    $display("[TB] continuous frames");
    wait_idle();
    continuous = 1'b1;
    apply_stimulus(1, 0, 2);
    tick();
    apply_stimulus(0, 0, 2);
    fd_seen = 0;
    for (int c = 0; c < 200 && fd_seen < 3; c++) begin
      tick();
      if (b_frame_done) begin
        fd_seen++;
        check_output($sformatf("cont_fd_state%0d", fd_seen), 32'(b_state_o),
                     (fd_seen < 3) ? 32'd5 : 32'd0);
        if (fd_seen == 2) continuous = 1'b0;
        if (fd_seen < 3) begin
          tick();
          check_output($sformatf("cont_erase%0d", fd_seen), 32'(b_state_o), 32'd1);
        end
      end
    end
    check_output("cont_frames", 32'(fd_seen), 32'd3);
    continuous = 1'b0;
`else
    fd_seen = 0;
`endif

    // Random traffic against the reference model.
    $display("[TB] random traffic");
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0,
                     int'($urandom_range(0, 12)));
`ifdef PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN
      continuous = ($urandom_range(0, 3) != 0);
`endif
      tick();
    end
    continuous = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_sequencer.md
Name: pixel_frame_sequencer

Overview:
Synthesizable frame controller for PIXEL_ARRAY. It sequences the erase, expose, convert and read phases with programmable phase lengths, and generates the digital ramp code used during conversion. It sits between the system control logic and the pixel array, driving the array's ERASE, EXPOSE, WRITE_ENABLE, COUNTER_RESET, READ_CLK_IN and POWER_ENABLE pins, plus the ramp gate.

Parameters:
BIT_DEPTH, 8, width of ramp_code
C_ERASE, 5, ERASE phase length in cycles (>=1)
C_CONVERT, 255, CONVERT phase length in cycles (>=1, <=2**BIT_DEPTH-1)
C_READ, 5, READ phase length in cycles (>=1)
EXP_W, 16, width of expose_cycles

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  begin one frame; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE
expose_cycles  input  EXP_W  exposure length in cycles; latched when start is accepted
erase  output  1  pixel erase
expose  output  1  exposure enable (gates VBN1)
ramp_en  output  1  convert enable (gates ANALOG_RAMP/COUNTER_CLOCK)
write_enable  output  1  high in EXPOSE and CONVERT
counter_reset  output  1  one-cycle pulse after CONVERT
read  output  1  array readout enable
power_enable  output  1  high in EXPOSE, CONVERT, READ
ramp_code  output  BIT_DEPTH  digital ramp value
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse on frame completion
state_o  output  3  current state encoding

Behaviour:
- State encodings: IDLE=0, ERASE=1, EXPOSE=2, CONVERT=3, READ=4, GAP=5.
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Phase counter, latched exposure value and every output go to 0.
  - Recovery from reset is synchronous on the first posedge with reset=1.
- Outputs are registered and decoded from the current state register. They change on the same posedge as the state, with no extra cycle of lag.
- IDLE:
  - start=1 and abort=0 at posedge k: latch exp_len = max(expose_cycles, 1); ERASE is active from cycle k+1.
  - start=1 and abort=1 in the same cycle: abort wins, state stays IDLE.
- Phase sequence: ERASE(C_ERASE) -> GAP -> EXPOSE(exp_len) -> GAP -> CONVERT(C_CONVERT) -> GAP -> READ(C_READ) -> IDLE.
  - Each phase lasts exactly its count of cycles.
  - GAP always lasts 1 cycle with all phase outputs low. GAP keeps an internal record of the next phase.
- Output decode:
  - erase=ERASE.
  - expose=EXPOSE.
  - ramp_en=CONVERT.
  - read=READ.
  - write_enable=EXPOSE|CONVERT.
  - power_enable=EXPOSE|CONVERT|READ.
  - busy = state!=IDLE.
- counter_reset is 1 only in the GAP cycle that follows CONVERT.
- ramp_code:
  - Value is 0 in the first CONVERT cycle and increments by 1 each CONVERT cycle, reaching C_CONVERT-1 in the last cycle.
  - Forced to 0 in every other state.
  - No wrap occurs within a frame, because C_CONVERT <= 2**BIT_DEPTH-1.
- frame_done is 1 for exactly the first IDLE cycle after READ completes.
- The phase counter counts down from (length-1) and reloads on each phase entry. exp_len is full EXP_W width, with no truncation.
- Timing with defaults and expose_cycles=255, start sampled at posedge k:
  - ERASE k+1..k+5
  - GAP k+6
  - EXPOSE k+7..k+261
  - GAP k+262
  - CONVERT k+263..k+517
  - GAP k+518 (counter_reset=1)
  - READ k+519..k+523
  - frame_done=1 at k+524
- abort=1 in any non-IDLE state:
  - State is IDLE at the next posedge and all outputs are 0.
  - No frame_done pulse and no counter_reset pulse are produced.
- start while busy is ignored and not queued.
- Changes to expose_cycles during a frame have no effect until the next accepted start.

Optional Feature:
- Macro: PIXEL_FRAME_SEQUENCER_CONTINUOUS_EN
- Defined:
  - An extra input port `continuous` (1 bit) is added.
  - If continuous=1 when READ completes: frame_done still pulses and the next state is GAP, then ERASE. A new frame starts with expose_cycles re-latched in that GAP cycle.
  - If continuous=0 when READ completes: return to IDLE as normal.
  - abort still returns to IDLE from any state.
- Undefined: the port is absent and READ always returns to IDLE.

Test Plan:
- reset=0 mid-CONVERT (ramp_code=100) -> all outputs 0 and state_o=0 immediately, with no clock needed; after release, stays IDLE until start.
- Defaults, expose_cycles=255, start pulse at posedge k -> phase windows exactly as listed in the timing above; counter_reset high only at k+518; frame_done only at k+524; ramp_code 0..254 during CONVERT.
- expose_cycles=0, then expose_cycles=3 -> EXPOSE lasts 1 cycle, then 3 cycles; with C_CONVERT=4, ramp_code sequence is 0,1,2,3 and then 0.
- abort=1 on the 10th EXPOSE cycle -> IDLE next cycle, busy=0, no frame_done and no counter_reset. start held with abort in IDLE -> no frame begins.
- start pulsed during READ, and expose_cycles changed mid-frame -> no second frame starts and the current EXPOSE length is unchanged.
- Macro defined, continuous=1, expose_cycles=2, small C_* values -> frame_done pulses, then GAP, then ERASE back-to-back across 3 frames. Dropping continuous in frame 3 -> IDLE after frame 3.
